// File: rtl/softmax_frame_decoder.sv
// softmax_frame_decoder: expands mini-float softmax results to Q1.8, emits
// them one per cycle, and builds a per-frame summary (argmax, max, saturating
// sum, element count, overflow) that is presented under a valid/ready handshake.
//
// Handshake semantics: a transfer happens on a rising edge where valid && ready
// are both high. A valid source holds its payload stable until the transfer,
// and ready never depends combinationally on valid.
module softmax_frame_decoder #(
   parameter int N_CLASSES = 8,
   parameter int IDX_W     = 3,
   parameter int ACC_W     = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_mant,
   input  logic [3:0]       in_exp,
   input  logic             in_last,
   output logic             fx_valid,
   output logic [8:0]       fx_out,
   output logic             frame_valid,
   input  logic             frame_ready,
   output logic [IDX_W-1:0] argmax_idx,
   output logic [8:0]       max_fx,
   output logic [ACC_W-1:0] sum_fx,
   output logic [3:0]       count,
   output logic             overflow,
   output logic             state_dbg
);

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   localparam logic [4:0] N_CLS = 5'(N_CLASSES);

   state_t           state_q, state_d;
   logic             fx_valid_q, fx_valid_d;
   logic [8:0]       fx_out_q, fx_out_d;

   // running accumulators for the frame currently being received
   logic [3:0]       run_cnt_q, run_cnt_d;
   logic [8:0]       run_max_q, run_max_d;
   logic [IDX_W-1:0] run_arg_q, run_arg_d;
   logic [ACC_W-1:0] run_sum_q, run_sum_d;
   logic             run_ovf_q, run_ovf_d;

   // latched summary of the last completed frame; survives the handshake
   logic [3:0]       sum_cnt_q, sum_cnt_d;
   logic [8:0]       sum_max_q, sum_max_d;
   logic [IDX_W-1:0] sum_arg_q, sum_arg_d;
   logic [ACC_W-1:0] sum_sum_q, sum_sum_d;
   logic             sum_ovf_q, sum_ovf_d;

   logic [8:0]       base_val;
   logic [8:0]       elem_val;
   logic             accept;
   logic             idx_in_range;
   logic [ACC_W:0]   sum_ext;

   // mini-float to Q1.8: implicit leading one, exponent is a right shift,
   // exponent 4'hF is the reserved zero code
   assign base_val = {1'b1, in_mant, 5'b00000};
   assign elem_val = (in_exp == 4'hF) ? 9'd0 : (base_val >> in_exp);

   assign in_ready     = (state_q == ACCUM);
   assign accept       = in_valid && in_ready;
   assign idx_in_range = ({1'b0, run_cnt_q} < N_CLS);
   assign sum_ext      = {1'b0, run_sum_q} + (ACC_W+1)'(elem_val);

   // next-state, element expansion and accumulator update
   always_comb begin
      state_d    = state_q;
      fx_valid_d = 1'b0;
      fx_out_d   = fx_out_q;
      run_cnt_d  = run_cnt_q;
      run_max_d  = run_max_q;
      run_arg_d  = run_arg_q;
      run_sum_d  = run_sum_q;
      run_ovf_d  = run_ovf_q;
      sum_cnt_d  = sum_cnt_q;
      sum_max_d  = sum_max_q;
      sum_arg_d  = sum_arg_q;
      sum_sum_d  = sum_sum_q;
      sum_ovf_d  = sum_ovf_q;

      case (state_q)
         ACCUM: begin
            if (accept) begin
               fx_valid_d = 1'b1;
               fx_out_d   = elem_val;
               // strict compare keeps the earliest index on ties
               if (idx_in_range && ((run_cnt_q == 4'd0) || (elem_val > run_max_q))) begin
                  run_max_d = elem_val;
                  run_arg_d = IDX_W'(run_cnt_q);
               end
               if (sum_ext[ACC_W]) begin
                  run_sum_d = '1;
               end else begin
                  run_sum_d = sum_ext[ACC_W-1:0];
               end
               if (run_cnt_q != 4'hF) begin
                  run_cnt_d = run_cnt_q + 4'd1;
               end
               if (!idx_in_range) begin
                  run_ovf_d = 1'b1;
               end
               if (in_last) begin
                  state_d   = HOLD;
                  sum_cnt_d = run_cnt_d;
                  sum_max_d = run_max_d;
                  sum_arg_d = run_arg_d;
                  sum_sum_d = run_sum_d;
                  sum_ovf_d = run_ovf_d;
               end
            end
         end
         HOLD: begin
            if (frame_ready) begin
               state_d   = ACCUM;
               run_cnt_d = '0;
               run_max_d = '0;
               run_arg_d = '0;
               run_sum_d = '0;
               run_ovf_d = 1'b0;
            end
         end
         default: begin
            state_d = ACCUM;
         end
      endcase
   end

   // state and datapath registers; reset discards any partial frame
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ACCUM;
         fx_valid_q <= 1'b0;
         fx_out_q   <= '0;
         run_cnt_q  <= '0;
         run_max_q  <= '0;
         run_arg_q  <= '0;
         run_sum_q  <= '0;
         run_ovf_q  <= 1'b0;
         sum_cnt_q  <= '0;
         sum_max_q  <= '0;
         sum_arg_q  <= '0;
         sum_sum_q  <= '0;
         sum_ovf_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         fx_valid_q <= fx_valid_d;
         fx_out_q   <= fx_out_d;
         run_cnt_q  <= run_cnt_d;
         run_max_q  <= run_max_d;
         run_arg_q  <= run_arg_d;
         run_sum_q  <= run_sum_d;
         run_ovf_q  <= run_ovf_d;
         sum_cnt_q  <= sum_cnt_d;
         sum_max_q  <= sum_max_d;
         sum_arg_q  <= sum_arg_d;
         sum_sum_q  <= sum_sum_d;
         sum_ovf_q  <= sum_ovf_d;
      end
   end

   assign fx_valid    = fx_valid_q;
   assign fx_out      = fx_out_q;
   assign frame_valid = (state_q == HOLD);
   assign argmax_idx  = sum_arg_q;
   assign max_fx      = sum_max_q;
   assign sum_fx      = sum_sum_q;
   assign count       = sum_cnt_q;
   assign overflow    = sum_ovf_q;
   assign state_dbg   = state_q;

endmodule

// File: doc/softmax_frame_decoder.md
Name: softmax_frame_decoder

Overview:
Consumer end of the pseudo-softmax result interface. Accepts a stream of mini-float results ({exp[3:0], mant[2:0]}), one per class. Each result is expanded to unsigned Q1.8 fixed point and emitted per element. Per frame, the block tracks argmax, max value, saturating sum and element count, then presents a frame summary with a valid/ready handshake. It sits after the softmax core and drives the classification/readout logic.

Parameters:
N_CLASSES, 8, number of classes considered for argmax; elements beyond this are counted but do not enter argmax/max.
IDX_W, 3, width of argmax index; must satisfy 2^IDX_W >= N_CLASSES.
ACC_W, 12, width of the saturating frame sum.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  element present on in_mant/in_exp/in_last
in_ready  output  1  block can accept an element; element accepted when in_valid && in_ready
in_mant  input  3  mantissa fraction bits
in_exp  input  4  negative exponent; 4'hF encodes zero
in_last  input  1  accepted element is the last of its frame
fx_valid  output  1  one-cycle pulse, fx_out holds the expanded element
fx_out  output  9  element value in Q1.8 (256 = 1.0)
frame_valid  output  1  frame summary valid, held until frame_ready
frame_ready  input  1  downstream accepts summary
argmax_idx  output  IDX_W  index of first maximum element
max_fx  output  9  maximum element value
sum_fx  output  ACC_W  saturating sum of all element values in frame
count  output  4  elements in frame, saturating at 15
overflow  output  1  frame held more than N_CLASSES elements

Behaviour:
- Reset (rst=1 at clk edge): in_ready=1; fx_valid=0; fx_out=0; frame_valid=0; argmax_idx=0; max_fx=0; sum_fx=0; count=0; overflow=0. FSM goes to ACCUM. Running accumulators are cleared. A partial frame is discarded, with no summary produced.
- Expansion: if in_exp==4'hF, value=0. Otherwise value = ({1'b1,in_mant} << 5) >> in_exp, truncated to 9 bits. Range is 256..480 at exp=0; exp>=9 gives 0.
- Element latency: an element accepted at edge T drives fx_valid=1 and fx_out=value for the cycle after T. fx_valid is 0 otherwise.
- FSM ACCUM: in_ready=1. On each accepted element:
  - idx = running count. If idx < N_CLASSES and (idx==0 or value > running max), update max and argmax to this element. Ties keep the earlier index.
  - sum += value, saturating at 2^ACC_W-1.
  - count += 1, saturating at 15.
  - If idx >= N_CLASSES, set overflow.
  - If in_last, go to HOLD.
- Summary latency: when the in_last element is accepted at T, frame_valid=1 from T+1. The summary includes that element.
- FSM HOLD: in_ready=0 and frame_valid=1. All summary outputs hold stable. in_valid is ignored; nothing is accepted and nothing is lost from the block's view.
  - On frame_valid && frame_ready at edge T: frame_valid=0 and in_ready=1 from T+1. Running accumulators are cleared and the FSM returns to ACCUM.
  - Summary outputs keep their last values after the handshake until the next frame completes.
- A single-element frame (in_last on the first element) gives argmax=0, max=sum=value, count=1.
- Back-to-back frames: the first element of the next frame can be accepted no earlier than the cycle after the summary handshake.
- rst has priority over every other event, including a simultaneous handshake or acceptance.

Test Plan:
- Expansion singles: (exp0,m0)->fx 256; (exp1,m4)->192; (exp0,m7)->480; (exp10,m7)->0; (expF,m5)->0. Each fx_valid pulse appears exactly 1 cycle after acceptance.
- Frame of 4: (exp2,m0),(exp1,m0),(exp3,m0),(exp3,m0 last) -> fx 64,128,32,32. Summary: argmax 1, max 128, sum 256, count 4, overflow 0. frame_valid rises the cycle after the last acceptance.
- Tie: (exp1,m0),(exp1,m0 last) -> argmax 0, max 128, sum 256, count 2.
- Backpressure: hold frame_ready=0 for 3 cycles while pulsing in_valid. Required: in_ready=0, no fx_valid, summary stable. Raise frame_ready -> frame_valid=0 and in_ready=1 next cycle. Following frame starts with clean accumulators.
- Overflow/saturation: 16 elements of (exp0,m7), with in_last on the 16th. Required: count 15, overflow 1, sum 4095, max 480, argmax 0.
- Reset mid-frame: 2 elements accepted, then rst=1 for 1 cycle. Required: all outputs at reset values. A new 1-element frame (exp1,m0 last) gives sum 128, count 1.
